// File: rtl/pc_seq_ctl_pkg.sv
// pc_seq_ctl_pkg: shared widths, reset PC, sequencer state encoding and
// flow-strobe priority decode for the next-PC controller.
package pc_seq_ctl_pkg;

    localparam int PC_W = 14;
    localparam logic [PC_W-1:0] RST_PC = 14'h0000;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        IACK = 2'b01,
        HALT = 2'b10
    } seq_state_t;

    // Enum ordering doubles as the strobe priority rank (higher wins).
    typedef enum logic [2:0] {
        FLOW_NONE = 3'd0,
        FLOW_JUMP = 3'd1,
        FLOW_CALL = 3'd2,
        FLOW_RTS  = 3'd3,
        FLOW_RTI  = 3'd4
    } flow_t;

    function automatic flow_t decode_flow(input logic rti, input logic rts,
                                          input logic call, input logic jump);
        if (rti)       return FLOW_RTI;
        else if (rts)  return FLOW_RTS;
        else if (call) return FLOW_CALL;
        else if (jump) return FLOW_JUMP;
        else           return FLOW_NONE;
    endfunction

endpackage

// File: rtl/pc_seq_ctl_if.sv
// pc_seq_ctl_if: sequencer <-> PC stack bus. The controller is the master
// (drives push/pop/write data/clock enable), the stack is the slave.
interface pc_seq_ctl_if #(
    parameter int PC_W = 14
) ();
    logic [PC_W-1:0] TopPC;
    logic            PC_full;
    logic            PC_empty;
    logic [PC_W-1:0] PCin;
    logic            PushPC_EN;
    logic            PopPC_EN;
    logic            PCS_CKenb;

    modport master (
        input  TopPC, PC_full, PC_empty,
        output PCin, PushPC_EN, PopPC_EN, PCS_CKenb
    );

    modport slave (
        output TopPC, PC_full, PC_empty,
        input  PCin, PushPC_EN, PopPC_EN, PCS_CKenb
    );
endinterface

// File: rtl/pc_seq_err.sv
// pc_seq_err: sticky stack overflow/underflow flags. ERR_CLR wins over an
// error raised in the same cycle; HOLD freezes the flags.
module pc_seq_err (
    input  logic DSPCLK,
    input  logic T_RST,
    input  logic HOLD,
    input  logic push_req,
    input  logic pop_req,
    input  logic PC_full,
    input  logic PC_empty,
    input  logic ERR_CLR,
    output logic STKOVF,
    output logic STKUNF
);

    // Set a flag when a push/pop is attempted against a full/empty stack.
    always_ff @(posedge DSPCLK) begin
        if (T_RST) begin
            STKOVF <= 1'b0;
            STKUNF <= 1'b0;
        end else if (!HOLD) begin
            if (ERR_CLR) begin
                STKOVF <= 1'b0;
                STKUNF <= 1'b0;
            end else begin
                if (push_req && PC_full)  STKOVF <= 1'b1;
                if (pop_req  && PC_empty) STKUNF <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_seq_ctl.sv
// pc_seq_ctl: program-sequencer next-PC controller in front of the 16-deep
// PC stack. Optional build macro PCS_TRAP_EN: a stack overflow/underflow
// also parks the sequencer in HALT until ERR_CLR.
module pc_seq_ctl #(
    parameter int PC_W = pc_seq_ctl_pkg::PC_W,
    parameter logic [PC_W-1:0] RST_PC = pc_seq_ctl_pkg::RST_PC
) (
    input  logic              DSPCLK,
    input  logic              T_RST,
    input  logic              HOLD,
    input  logic              Call_E,
    input  logic              Jump_E,
    input  logic              Rts_E,
    input  logic              Rti_E,
    input  logic              Ei_E,
    input  logic              Di_E,
    input  logic [PC_W-1:0]   Target,
    input  logic              IRQ_req,
    input  logic [PC_W-1:0]   IRQ_vec,
    input  logic              ERR_CLR,
    pc_seq_ctl_if.master      stk,
    output logic [PC_W-1:0]   PC,
    output logic              IRQ_ack,
    output logic              IE,
    output logic              STKOVF,
    output logic              STKUNF,
    output logic              HALTED
);
    import pc_seq_ctl_pkg::*;

    seq_state_t      state;
    flow_t           flow;
    logic            irq_accept;
    logic            run_exec;
    logic            iack_go;
    logic            push_req;
    logic            pop_req;
    logic [PC_W-1:0] pc_inc;

    // Decode this cycle's stack requests; reset and HOLD suppress everything.
    always_comb begin
        irq_accept = (state == RUN) && IRQ_req && IE && !HOLD && !T_RST;
        run_exec   = (state == RUN) && !HOLD && !T_RST && !irq_accept;
        iack_go    = (state == IACK) && !HOLD && !T_RST;
        flow       = FLOW_NONE;
        if (run_exec) flow = decode_flow(Rti_E, Rts_E, Call_E, Jump_E);
        push_req   = (flow == FLOW_CALL) || iack_go;
        pop_req    = (flow == FLOW_RTS) || (flow == FLOW_RTI);
        pc_inc     = PC + PC_W'(1);
    end

    assign stk.PushPC_EN = push_req && !stk.PC_full;
    assign stk.PopPC_EN  = pop_req && !stk.PC_empty;
    assign stk.PCS_CKenb = !(stk.PushPC_EN || stk.PopPC_EN);
    assign stk.PCin      = (state == IACK) ? PC : pc_inc;
    assign IRQ_ack       = iack_go;

`ifdef PCS_TRAP_EN
    logic err_evt;
    assign err_evt = (push_req && stk.PC_full) || (pop_req && stk.PC_empty);
    assign HALTED  = (state == HALT);
`else
    assign HALTED  = 1'b0;
`endif

    pc_seq_err u_err (
        .DSPCLK   (DSPCLK),
        .T_RST    (T_RST),
        .HOLD     (HOLD),
        .push_req (push_req),
        .pop_req  (pop_req),
        .PC_full  (stk.PC_full),
        .PC_empty (stk.PC_empty),
        .ERR_CLR  (ERR_CLR),
        .STKOVF   (STKOVF),
        .STKUNF   (STKUNF)
    );

    // Sequencer FSM: advances PC, takes interrupts and tracks interrupt enable.
    always_ff @(posedge DSPCLK) begin
        if (T_RST) begin
            state <= RUN;
            PC    <= RST_PC;
            IE    <= 1'b0;
        end else if (!HOLD) begin
            case (state)
                RUN: begin
                    if (irq_accept) begin
                        IE    <= 1'b0;
                        state <= IACK;
                    end
`ifdef PCS_TRAP_EN
                    else if (err_evt && !ERR_CLR) begin
                        state <= HALT;
                    end
`endif
                    else begin
                        case (flow)
                            FLOW_JUMP, FLOW_CALL: PC <= Target;
                            FLOW_RTS, FLOW_RTI:   PC <= stk.TopPC;
                            default:              PC <= pc_inc;
                        endcase
                        if (flow == FLOW_RTI) IE <= 1'b1;
                        if (Di_E)             IE <= 1'b0;
                        else if (Ei_E)        IE <= 1'b1;
                    end
                end
                IACK: begin
`ifdef PCS_TRAP_EN
                    if (err_evt && !ERR_CLR) begin
                        state <= HALT;
                    end else begin
                        PC    <= IRQ_vec;
                        state <= RUN;
                    end
`else
                    PC    <= IRQ_vec;
                    state <= RUN;
`endif
                end
                HALT: begin
`ifdef PCS_TRAP_EN
                    if (ERR_CLR) state <= RUN;
`else
                    state <= RUN;
`endif
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctl.sv
// tb_pc_seq_ctl: scoreboard bench for pc_seq_ctl with a behavioural 16-deep
// PC stack model attached to the stack interface. Honours PCS_TRAP_EN.
module tb_pc_seq_ctl;

    logic        DSPCLK = 1'b0;
    logic        T_RST, HOLD, Call_E, Jump_E, Rts_E, Rti_E, Ei_E, Di_E;
    logic [13:0] Target, IRQ_vec;
    logic        IRQ_req, ERR_CLR;
    logic [13:0] PC;
    logic        IRQ_ack, IE, STKOVF, STKUNF, HALTED;

    pc_seq_ctl_if #(.PC_W(14)) stk ();

    pc_seq_ctl dut (
        .DSPCLK  (DSPCLK),
        .T_RST   (T_RST),
        .HOLD    (HOLD),
        .Call_E  (Call_E),
        .Jump_E  (Jump_E),
        .Rts_E   (Rts_E),
        .Rti_E   (Rti_E),
        .Ei_E    (Ei_E),
        .Di_E    (Di_E),
        .Target  (Target),
        .IRQ_req (IRQ_req),
        .IRQ_vec (IRQ_vec),
        .ERR_CLR (ERR_CLR),
        .stk     (stk),
        .PC      (PC),
        .IRQ_ack (IRQ_ack),
        .IE      (IE),
        .STKOVF  (STKOVF),
        .STKUNF  (STKUNF),
        .HALTED  (HALTED)
    );

    always #5 DSPCLK = ~DSPCLK;

    // Behavioural PC stack; an empty stack presents a recognisable junk top.
    logic [13:0] stkMem [16];
    int          sp = 0;

    assign stk.TopPC    = (sp == 0) ? 14'h1234 : stkMem[sp-1];
    assign stk.PC_full  = (sp == 16);
    assign stk.PC_empty = (sp == 0);

    // Stack model commits push/pop on the controller's requests.
    always @(posedge DSPCLK) begin
        if (stk.PushPC_EN && sp < 16) begin
            stkMem[sp] <= stk.PCin;
            sp         <= sp + 1;
        end else if (stk.PopPC_EN && sp > 0) begin
            sp <= sp - 1;
        end
    end

    typedef struct {
        string       tag;
        logic        push;
        logic        pop;
        logic [13:0] pcin;
        logic        ack;
        logic [13:0] pc;
        logic        ie;
        logic        ovf;
        logic        unf;
        logic        halted;
    } exp_t;

    exp_t sbq [$];
    int   vecCount  = 0;
    int   missCount = 0;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearIn();
        T_RST = 1'b0; HOLD = 1'b0; Call_E = 1'b0; Jump_E = 1'b0; Rts_E = 1'b0;
        Rti_E = 1'b0; Ei_E = 1'b0; Di_E = 1'b0; IRQ_req = 1'b0; ERR_CLR = 1'b0;
    endtask

    // Pop one expected cycle: combinational outputs first, registers after the edge.
    task automatic sampleCycle();
        exp_t e;
        e = sbq.pop_front();
        #1;
        checkOutput({e.tag, ".push"},  32'(stk.PushPC_EN), 32'(e.push));
        checkOutput({e.tag, ".pop"},   32'(stk.PopPC_EN),  32'(e.pop));
        checkOutput({e.tag, ".ckenb"}, 32'(stk.PCS_CKenb), 32'(!(e.push || e.pop)));
        checkOutput({e.tag, ".ack"},   32'(IRQ_ack),       32'(e.ack));
        if (e.push) checkOutput({e.tag, ".pcin"}, 32'(stk.PCin), 32'(e.pcin));
        @(posedge DSPCLK);
        #1;
        checkOutput({e.tag, ".pc"},     32'(PC),     32'(e.pc));
        checkOutput({e.tag, ".ie"},     32'(IE),     32'(e.ie));
        checkOutput({e.tag, ".ovf"},    32'(STKOVF), 32'(e.ovf));
        checkOutput({e.tag, ".unf"},    32'(STKUNF), 32'(e.unf));
        checkOutput({e.tag, ".halted"}, 32'(HALTED), 32'(e.halted));
        @(negedge DSPCLK);
    endtask

    // Queue the expectation for the inputs currently driven, then run the cycle.
    task automatic applyStimulus(input string tag, input logic ePush, input logic ePop,
                                 input logic [13:0] ePcin, input logic eAck,
                                 input logic [13:0] ePc, input logic eIe,
                                 input logic eOvf, input logic eUnf, input logic eHalted);
        exp_t e;
        e.tag = tag; e.push = ePush; e.pop = ePop; e.pcin = ePcin; e.ack = eAck;
        e.pc = ePc; e.ie = eIe; e.ovf = eOvf; e.unf = eUnf; e.halted = eHalted;
        sbq.push_back(e);
        sampleCycle();
        clearIn();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [13:0] pushed [16];
        logic [13:0] curPc;
        logic [13:0] tgt;

        clearIn();
        Target  = 14'h0;
        IRQ_vec = 14'h0;

        // Reset with a Call strobe present: nothing may be pushed.
        T_RST = 1'b1; Call_E = 1'b1;
        applyStimulus("reset", 0, 0, 14'h0, 0, 14'h0000, 0, 0, 0, 0);

        applyStimulus("idle1", 0, 0, 14'h0, 0, 14'h0001, 0, 0, 0, 0);
        applyStimulus("idle2", 0, 0, 14'h0, 0, 14'h0002, 0, 0, 0, 0);
        applyStimulus("idle3", 0, 0, 14'h0, 0, 14'h0003, 0, 0, 0, 0);

        Jump_E = 1'b1; Target = 14'h0010;
        applyStimulus("jump10", 0, 0, 14'h0, 0, 14'h0010, 0, 0, 0, 0);
        Call_E = 1'b1; Target = 14'h0100;
        applyStimulus("call100", 1, 0, 14'h0011, 0, 14'h0100, 0, 0, 0, 0);
        Rts_E = 1'b1;
        applyStimulus("rts", 0, 1, 14'h0, 0, 14'h0011, 0, 0, 0, 0);

        Ei_E = 1'b1;
        applyStimulus("ei", 0, 0, 14'h0, 0, 14'h0012, 1, 0, 0, 0);
        Jump_E = 1'b1; Target = 14'h0050;
        applyStimulus("jump50", 0, 0, 14'h0, 0, 14'h0050, 1, 0, 0, 0);

        // Interrupt accept ignores the coincident Call.
        IRQ_req = 1'b1; IRQ_vec = 14'h0200; Call_E = 1'b1; Target = 14'h0777;
        applyStimulus("irqacc", 0, 0, 14'h0, 0, 14'h0050, 0, 0, 0, 0);
        applyStimulus("iack", 1, 0, 14'h0050, 1, 14'h0200, 0, 0, 0, 0);
        Rti_E = 1'b1;
        applyStimulus("rti", 0, 1, 14'h0, 0, 14'h0050, 1, 0, 0, 0);

        // HOLD for three cycles while in IACK.
        IRQ_req = 1'b1;
        applyStimulus("irqacc2", 0, 0, 14'h0, 0, 14'h0050, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            HOLD = 1'b1;
            applyStimulus("iackhold", 0, 0, 14'h0, 0, 14'h0050, 0, 0, 0, 0);
        end
        applyStimulus("iack2", 1, 0, 14'h0050, 1, 14'h0200, 0, 0, 0, 0);
        Rti_E = 1'b1;
        applyStimulus("rti2", 0, 1, 14'h0, 0, 14'h0050, 1, 0, 0, 0);

        // Reset arriving while in IACK.
        IRQ_req = 1'b1;
        applyStimulus("irqacc3", 0, 0, 14'h0, 0, 14'h0050, 0, 0, 0, 0);
        T_RST = 1'b1;
        applyStimulus("rstiack", 0, 0, 14'h0, 0, 14'h0000, 0, 0, 0, 0);
        applyStimulus("postrst", 0, 0, 14'h0, 0, 14'h0001, 0, 0, 0, 0);

        // HOLD in RUN blocks a Call.
        HOLD = 1'b1; Call_E = 1'b1; Target = 14'h0400;
        applyStimulus("holdcall", 0, 0, 14'h0, 0, 14'h0001, 0, 0, 0, 0);

        // PC wrap.
        Jump_E = 1'b1; Target = 14'h3FFF;
        applyStimulus("jump3fff", 0, 0, 14'h0, 0, 14'h3FFF, 0, 0, 0, 0);
        applyStimulus("wrap", 0, 0, 14'h0, 0, 14'h0000, 0, 0, 0, 0);

        // Underflow.
        Rts_E = 1'b1;
`ifdef PCS_TRAP_EN
        applyStimulus("unf", 0, 0, 14'h0, 0, 14'h0000, 0, 0, 1, 1);
        Call_E = 1'b1; Target = 14'h0777;
        applyStimulus("unfhalt", 0, 0, 14'h0, 0, 14'h0000, 0, 0, 1, 1);
        ERR_CLR = 1'b1;
        applyStimulus("unfclr", 0, 0, 14'h0, 0, 14'h0000, 0, 0, 0, 0);
`else
        applyStimulus("unf", 0, 0, 14'h0, 0, 14'h1234, 0, 0, 1, 0);
        ERR_CLR = 1'b1;
        applyStimulus("unfclr", 0, 0, 14'h0, 0, 14'h1235, 0, 0, 0, 0);
`endif
        Rts_E = 1'b1; ERR_CLR = 1'b1;
        applyStimulus("clrprec", 0, 0, 14'h0, 0, 14'h1234, 0, 0, 0, 0);

        // Fill the stack with 16 nested calls.
        curPc = 14'h1234;
        for (int i = 0; i < 16; i++) begin
            tgt       = 14'h0200 + 14'(i * 4);
            pushed[i] = curPc + 14'h1;
            Call_E = 1'b1; Target = tgt;
            applyStimulus("nestcall", 1, 0, pushed[i], 0, tgt, 0, 0, 0, 0);
            curPc = tgt;
        end

        // 17th call overflows.
        Call_E = 1'b1; Target = 14'h0300;
`ifdef PCS_TRAP_EN
        applyStimulus("ovf", 0, 0, 14'h0, 0, curPc, 0, 1, 0, 1);
        Jump_E = 1'b1; Target = 14'h0555;
        applyStimulus("ovfhalt", 0, 0, 14'h0, 0, curPc, 0, 1, 0, 1);
        ERR_CLR = 1'b1;
        applyStimulus("ovfclr", 0, 0, 14'h0, 0, curPc, 0, 0, 0, 0);
`else
        applyStimulus("ovf", 0, 0, 14'h0, 0, 14'h0300, 0, 1, 0, 0);
        ERR_CLR = 1'b1;
        applyStimulus("ovfclr", 0, 0, 14'h0, 0, 14'h0301, 0, 0, 0, 0);
`endif

        // Back-to-back returns unwind in reverse order.
        for (int i = 15; i >= 0; i--) begin
            Rts_E = 1'b1;
            applyStimulus("unwind", 0, 1, 14'h0, 0, pushed[i], 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
